nand_flash: RTL and testbench
=============================

# nand_flash

Synthesizable behavioural model of the NAND flash device that sits on the far end of the flash controller's F_IO/F_CLE/F_ALE/F_REN/F_WEN/F_RB bus. It decodes bus cycles into commands and addresses and holds a page array and a page buffer. It serves page reads, serial data input and page program, and reports busy on F_RB. It is the device-side counterpart used in controller benches and system simulation.

## Interface
- PAGE_NUM, 512, number of pages; power of two; row address is taken modulo PAGE_NUM
- T_R, 8, read busy cycles (F_RB low) after the last read address cycle
- clk  input  1  clock; all bus inputs are sampled on its rising edge
- rst  input  1  reset; one clock, asynchronous, active-high
- F_CLE  input  1  command latch enable
- F_ALE  input  1  address latch enable
- F_WEN  input  1  write enable, active low
- F_REN  input  1  read enable, active low
- F_IO  inout  8  bidirectional data/command/address bus; Z unless driving read data
- F_RB  output  1  ready(1)/busy(0), registered

## Operation
- Bus capture (write side)
  - Every cycle with F_WEN=0: capture F_CLE, F_ALE and F_IO into holding registers.
  - The first cycle with F_WEN=1 after a cycle with F_WEN=0 is a WE-rise event. The captured values are acted on at that point.
  - Captured CLE=1: command. Captured ALE=1: address. Neither: data byte.
- Commands
  - FF: reset. Immediate return to IDLE from any state, including the busy states. Sets pointer=A and F_RB=1. No busy period.
  - 00/01: pointer=A/B (column bit 8 = 0/1). In IDLE or RD_OUT, move to ADDR in read mode.
  - 80: move to ADDR in write mode, keeping the pointer set by a preceding 00/01. Fill the page buffer with FF.
  - 10: valid only in WR_IN. Move to PROG_BUSY.
  - Any other command, or any command during RD_BUSY/PROG_BUSY other than FF: ignored.
- ADDR: 3 address cycles.
  - Cycle 0: col[7:0] = byte, col[8] = pointer.
  - Cycle 1: page[7:0].
  - Cycle 2: page[8] = bit 0.
  - After the 3rd cycle, read mode goes to RD_BUSY and write mode goes to WR_IN.
- RD_BUSY: F_RB=0 for T_R cycles, then F_RB=1 and move to RD_OUT.
- RD_OUT
  - F_IO = mem[page][col] combinationally while F_REN=0; otherwise F_IO is Z.
  - An RE-rise (F_REN=1 after a sampled 0) increments col.
- WR_IN: each data WE-rise writes buf[col] = byte, then increments col.
- PROG_BUSY
  - F_RB=0. Copy one byte per cycle for col 0..511: mem[page][col] = mem[page][col] & buf[col]. Programming only clears bits.
  - When the copy finishes: F_RB=1, pointer=A, IDLE.
- Column counter is 9 bits and wraps 511→0 within the same page, in both RD_OUT and WR_IN.
- mem is not reset. Power-up contents are all FF, and the bench may preload mem with $readmemh.

## Timing
- Reset values: state=IDLE, F_RB=1, F_IO=Z, pointer=A, col=0, page=0. Buffer contents are unchanged.
- rst asserted mid-program: the copy aborts and the page is left partially programmed.
- F_RB timing
  - F_RB falls at the same clock edge that processes the 3rd address WE-rise, so it is already 0 in the next cycle.
  - Read busy is exactly T_R cycles.
  - Program busy is exactly PAGE_BYTES = 512 cycles, starting at the edge that processes the 10 WE-rise.
- Read data is valid for the whole cycle in which F_REN=0. The first byte is the one addressed by the column address.
- F_IO is never driven while F_REN=1, so there is no contention with the controller driving command/address/data.
- A WE-rise and an RE-rise in the same cycle is a bus protocol error. The WE event is processed and the RE event is dropped.

## Structure
- Package nand_pkg holds:
  - command constants: CMD_RESET=FF, CMD_READ_A=00, CMD_READ_B=01, CMD_SEQIN=80, CMD_PROG=10
  - state enum: IDLE, ADDR, RD_BUSY, RD_OUT, WR_IN, PROG_BUSY
  - PAGE_BYTES=512
- Sub-module nand_bus_sync: WEN/REN sampling, low-phase capture of CLE/ALE/F_IO, and we_rise/re_rise pulses.

## Test plan
- Reset then read with no prior preload: rst pulse → F_RB=1 and F_IO=Z. Then cmd 00 and address 05,03,00 → F_RB low for 8 cycles, then 4 RE pulses return FF,FF,FF,FF.
- Preload mem[3][261..264]=11,22,33,44. Issue 01, address 05,03,00, wait for F_RB=1, then 4 RE pulses → 11,22,33,44.
- Issue 80, address 10,07,01 (page 263), data AA,55, then 10 → F_RB low for 512 cycles. A subsequent read of page 263 at col 16 → AA,55,FF.
- Program A0 at page 263 col 16, then program 0F at the same location → readback is 00, confirming AND semantics.
- Wrap-around: read from col 510 of page 0 with preload 01,02 at 510/511 and 03 at 0 → 01,02,03.
- Send FF during PROG_BUSY, and separately assert rst mid-copy → F_RB=1 within one cycle. The next 00 command is accepted normally.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared constants and state encoding for the NAND flash device model.
package nand_pkg;

    localparam int PAGE_BYTES = 512;
    localparam int COL_W      = 9;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_READ_A = 8'h00;
    localparam logic [7:0] CMD_READ_B = 8'h01;
    localparam logic [7:0] CMD_SEQIN  = 8'h80;
    localparam logic [7:0] CMD_PROG   = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_BUSY,
        RD_OUT,
        WR_IN,
        PROG_BUSY
    } state_t;

endpackage

// File: rtl/nand_flash_if.sv
// Control strobes and ready/busy between a flash controller and the device.
interface nand_flash_if;
    logic F_CLE;
    logic F_ALE;
    logic F_WEN;
    logic F_REN;
    logic F_RB;

    modport master (output F_CLE, F_ALE, F_WEN, F_REN, input F_RB);
    modport slave  (input F_CLE, F_ALE, F_WEN, F_REN, output F_RB);
endinterface

// File: rtl/nand_bus_sync.sv
// Samples WEN/REN, holds CLE/ALE/IO captured during WEN low, and flags rising strobes.
module nand_bus_sync
    import nand_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wen,
    input  logic       ren,
    input  logic       cle,
    input  logic       ale,
    input  logic [7:0] io,
    output logic       we_rise,
    output logic       re_rise,
    output logic       cap_cle,
    output logic       cap_ale,
    output logic [7:0] cap_io
);

    logic wen_low_q;
    logic ren_low_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_low_q <= 1'b0;
            ren_low_q <= 1'b0;
            cap_cle   <= 1'b0;
            cap_ale   <= 1'b0;
            cap_io    <= 8'h00;
        end else begin
            wen_low_q <= !wen;
            ren_low_q <= !ren;
            if (!wen) begin
                cap_cle <= cle;
                cap_ale <= ale;
                cap_io  <= io;
            end
        end
    end

    assign we_rise = wen && wen_low_q;
    // A simultaneous WE-rise wins; the RE edge is discarded as a protocol error.
    assign re_rise = ren && ren_low_q && !we_rise;

endmodule

// File: rtl/nand_flash.sv
// Behavioural NAND flash device: command/address decode, page read, serial input and program.
module nand_flash
    import nand_pkg::*;
#(
    parameter int PAGE_NUM = 512,
    parameter int T_R      = 8
) (
    input  logic         clk,
    input  logic         rst,
    nand_flash_if.slave  bus,
    inout  wire [7:0]    F_IO
);

    localparam int PAGE_W = $clog2(PAGE_NUM);
    localparam int TW     = $clog2(T_R + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAGE_BYTES - 1);

    logic [7:0] mem      [PAGE_NUM][PAGE_BYTES];
    logic [7:0] page_buf [PAGE_BYTES];

    state_t            state, state_nxt;
    logic              rb, rb_nxt, io_oe;
    logic              pointer_b, write_mode;
    logic [1:0]        addr_cnt;
    logic [COL_W-1:0]  col;
    logic [8:0]        row;
    logic [TW-1:0]     timer;
    logic [PAGE_W-1:0] page_idx;
    logic [7:0]        rd_data;

    logic       we_rise, re_rise, cap_cle, cap_ale;
    logic [7:0] cap_io;

    nand_bus_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .wen     (bus.F_WEN),
        .ren     (bus.F_REN),
        .cle     (bus.F_CLE),
        .ale     (bus.F_ALE),
        .io      (F_IO),
        .we_rise (we_rise),
        .re_rise (re_rise),
        .cap_cle (cap_cle),
        .cap_ale (cap_ale),
        .cap_io  (cap_io)
    );

    logic is_cmd, cmd_reset, start_read, start_seqin, start_prog;
    logic addr_cyc, last_addr, data_cyc;

    assign is_cmd      = we_rise && cap_cle;
    assign cmd_reset   = is_cmd && (cap_io == CMD_RESET);
    assign start_read  = is_cmd && (cap_io == CMD_READ_A || cap_io == CMD_READ_B)
                         && (state == IDLE || state == RD_OUT);
    assign start_seqin = is_cmd && (cap_io == CMD_SEQIN)
                         && (state != RD_BUSY) && (state != PROG_BUSY);
    assign start_prog  = is_cmd && (cap_io == CMD_PROG) && (state == WR_IN);
    assign addr_cyc    = we_rise && cap_ale && !cap_cle && (state == ADDR);
    assign last_addr   = addr_cyc && (addr_cnt == 2'd2);
    assign data_cyc    = we_rise && !cap_ale && !cap_cle && (state == WR_IN);

    assign page_idx = row[PAGE_W-1:0];
    assign rd_data  = mem[page_idx][col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rb    <= 1'b1;
        end else begin
            state <= state_nxt;
            rb    <= rb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cmd_reset)                                 state_nxt = IDLE;
        else if (start_read || start_seqin)            state_nxt = ADDR;
        else if (start_prog)                           state_nxt = PROG_BUSY;
        else if (last_addr)                            state_nxt = write_mode ? WR_IN : RD_BUSY;
        else if (state == RD_BUSY && timer == '0)      state_nxt = RD_OUT;
        else if (state == PROG_BUSY && col == COL_LAST) state_nxt = IDLE;
    end

    // Busy is driven from the next state so F_RB drops on the edge that starts the operation.
    always_comb begin
        rb_nxt = !(state_nxt == RD_BUSY || state_nxt == PROG_BUSY);
        io_oe  = (state == RD_OUT) && !bus.F_REN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer_b  <= 1'b0;
            write_mode <= 1'b0;
            addr_cnt   <= 2'd0;
            col        <= '0;
            row        <= '0;
            timer      <= '0;
        end else if (cmd_reset) begin
            pointer_b <= 1'b0;
            addr_cnt  <= 2'd0;
        end else if (start_read) begin
            pointer_b  <= cap_io[0];
            write_mode <= 1'b0;
            addr_cnt   <= 2'd0;
        end else if (start_seqin) begin
            write_mode <= 1'b1;
            addr_cnt   <= 2'd0;
        end else if (start_prog) begin
            col <= '0;
        end else if (addr_cyc) begin
            addr_cnt <= addr_cnt + 2'd1;
            timer    <= TW'(T_R - 1);
            case (addr_cnt)
                2'd0:    col      <= {pointer_b, cap_io};
                2'd1:    row[7:0] <= cap_io;
                default: row[8]   <= cap_io[0];
            endcase
        end else if (data_cyc || (state == RD_OUT && re_rise)) begin
            col <= col + 1'b1;
        end else if (state == RD_BUSY && timer != '0) begin
            timer <= timer - 1'b1;
        end else if (state == PROG_BUSY) begin
            col <= col + 1'b1;
            if (col == COL_LAST) pointer_b <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start_seqin) begin
            for (int i = 0; i < PAGE_BYTES; i++) page_buf[i] <= 8'hFF;
        end else if (data_cyc) begin
            page_buf[col] <= cap_io;
        end
    end

    // Array is left unreset so it can be preloaded and survives an aborted program.
    always @(posedge clk) begin
        if (state == PROG_BUSY && !cmd_reset)
            mem[page_idx][col] <= mem[page_idx][col] & page_buf[col];
    end

    assign F_IO   = io_oe ? rd_data : 8'hzz;
    assign bus.F_RB = rb;

endmodule

// File: tb/tb_nand_flash.sv
// Directed bench for nand_flash: read, program, AND semantics, column wrap and abort paths.
module tb_nand_flash;
    import nand_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nand_flash_if bus ();
    wire  [7:0] f_io;
    logic [7:0] io_drv;
    logic       io_en;
    assign f_io = io_en ? io_drv : 8'hzz;

    nand_flash #(.PAGE_NUM(512), .T_R(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .F_IO (f_io)
    );

    int errors = 0;
    int checks = 0;

    task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
        @(negedge clk);
        bus.F_WEN = 1'b0; bus.F_CLE = cle; bus.F_ALE = ale; io_drv = d; io_en = 1'b1;
        @(negedge clk);
        bus.F_WEN = 1'b1; bus.F_CLE = 1'b0; bus.F_ALE = 1'b0; io_en = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.F_RB) break;
            n++;
        end
    endtask

    task automatic rd(output logic [7:0] d);
        @(negedge clk);
        bus.F_REN = 1'b0;
        #1 d = f_io;
        @(negedge clk);
        bus.F_REN = 1'b1;
    endtask

    task automatic read_setup(input logic [7:0] c, input logic [7:0] c0,
                              input logic [7:0] r0, input logic [7:0] r1, output int n);
        wr(1, 0, c);
        wr(0, 1, c0); wr(0, 1, r0); wr(0, 1, r1);
        wait_ready(n);
    endtask

    task automatic prog_start(input logic [7:0] ptr, input logic [7:0] c0,
                              input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] d);
        wr(1, 0, ptr);
        wr(1, 0, CMD_SEQIN);
        wr(0, 1, c0); wr(0, 1, r0); wr(0, 1, r1);
        wr(0, 0, d);
        wr(1, 0, CMD_PROG);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int n;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (bus.F_RB !== 1'b1) begin errors++; $display("FAIL reset_rb got=%b exp=1", bus.F_RB); end
        checks++; if (dut.io_oe !== 1'b0) begin errors++; $display("FAIL reset_io_oe got=%b exp=0", dut.io_oe); end
        io_drv = 8'h5A; io_en = 1'b1;
        #1;
        checks++; if (f_io !== 8'h5A) begin errors++; $display("FAIL reset_bus_free got=%h exp=5a", f_io); end
        io_en = 1'b0;
        read_setup(CMD_READ_A, 8'h05, 8'h03, 8'h00, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL read_busy_len got=%0d exp=8", n); end
        for (int i = 0; i < 4; i++) begin
            rd(d);
            checks++; if (d !== 8'hFF) begin errors++; $display("FAIL erased_read[%0d] got=%h exp=ff", i, d); end
        end
    endtask

    task automatic test_preload_read();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] d;
        int n;
        for (int i = 0; i < 4; i++) dut.mem[3][261 + i] = exp_d[i];
        read_setup(CMD_READ_B, 8'h05, 8'h03, 8'h00, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL ptrb_busy_len got=%0d exp=8", n); end
        for (int i = 0; i < 4; i++) begin
            rd(d);
            checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL ptrb_read[%0d] got=%h exp=%h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_program();
        logic [7:0] exp_d [3] = '{8'hAA, 8'h55, 8'hFF};
        logic [7:0] d;
        int n;
        wr(1, 0, CMD_READ_A);
        wr(1, 0, CMD_SEQIN);
        wr(0, 1, 8'h10); wr(0, 1, 8'h07); wr(0, 1, 8'h01);
        wr(0, 0, 8'hAA); wr(0, 0, 8'h55);
        wr(1, 0, CMD_PROG);
        wait_ready(n);
        checks++; if (n !== 512) begin errors++; $display("FAIL prog_busy_len got=%0d exp=512", n); end
        read_setup(CMD_READ_A, 8'h10, 8'h07, 8'h01, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL prog_rd_busy got=%0d exp=8", n); end
        for (int i = 0; i < 3; i++) begin
            rd(d);
            checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL prog_read[%0d] got=%h exp=%h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_and_semantics();
        logic [7:0] d;
        int n;
        prog_start(CMD_READ_A, 8'h10, 8'h07, 8'h01, 8'hA0);
        wait_ready(n);
        read_setup(CMD_READ_A, 8'h10, 8'h07, 8'h01, n);
        rd(d);
        checks++; if (d !== 8'hA0) begin errors++; $display("FAIL and_first got=%h exp=a0", d); end
        prog_start(CMD_READ_A, 8'h10, 8'h07, 8'h01, 8'h0F);
        wait_ready(n);
        checks++; if (n !== 512) begin errors++; $display("FAIL and_busy_len got=%0d exp=512", n); end
        read_setup(CMD_READ_A, 8'h10, 8'h07, 8'h01, n);
        rd(d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL and_second got=%h exp=00", d); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] d;
        int n;
        dut.mem[0][510] = 8'h01;
        dut.mem[0][511] = 8'h02;
        dut.mem[0][0]   = 8'h03;
        read_setup(CMD_READ_B, 8'hFE, 8'h00, 8'h00, n);
        for (int i = 0; i < 3; i++) begin
            rd(d);
            checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL wrap_read[%0d] got=%h exp=%h", i, d, exp_d[i]); end
        end
    endtask

    task automatic test_prog_abort();
        logic [7:0] d;
        int n;
        prog_start(CMD_READ_A, 8'h00, 8'h05, 8'h00, 8'h00);
        repeat (20) @(negedge clk);
        checks++; if (bus.F_RB !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.F_RB); end
        wr(1, 0, CMD_RESET);
        @(negedge clk);
        checks++; if (bus.F_RB !== 1'b1) begin errors++; $display("FAIL ffcmd_ready got=%b exp=1", bus.F_RB); end
        read_setup(CMD_READ_A, 8'h00, 8'h05, 8'h00, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL after_ff_busy got=%0d exp=8", n); end
        rd(d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL after_ff_data got=%h exp=00", d); end

        prog_start(CMD_READ_B, 8'hF4, 8'h06, 8'h00, 8'h00);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.F_RB !== 1'b1) begin errors++; $display("FAIL rst_abort_ready got=%b exp=1", bus.F_RB); end
        @(negedge clk); rst = 1'b0;
        read_setup(CMD_READ_B, 8'hF4, 8'h06, 8'h00, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL after_rst_busy got=%0d exp=8", n); end
        rd(d);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL after_rst_data got=%h exp=ff", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.F_WEN = 1'b1; bus.F_REN = 1'b1; bus.F_CLE = 1'b0; bus.F_ALE = 1'b0;
        io_drv = 8'h00; io_en = 1'b0;
        for (int p = 0; p < 512; p++)
            for (int c = 0; c < 512; c++)
                dut.mem[p][c] = 8'hFF;
        test_reset();
        test_preload_read();
        test_program();
        test_and_semantics();
        test_wrap();
        test_prog_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
